// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round controller: owns the 128-bit state, the round
// counter and the stream handshakes around an external combinational round datapath.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [127:0]  i_block,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [127:0]  o_block,
  output logic [KW-1:0] o_key_idx,
  input  logic [127:0]  i_round_key,
  output logic [127:0]  o_dp_state,
  output logic          o_dp_final,
  input  logic [127:0]  i_dp_result,
  output logic          o_busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((1 << KW) <= NR) begin : g_bad_kw
    $error("aes_round_ctrl: KW too narrow to hold NR");
  end

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_e;

  localparam logic [KW-1:0] LAST_ROUND = KW'(NR);

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [KW-1:0] round_q, round_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // The key store reads index 0 while idle, so acceptance applies the initial AddRoundKey.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (i_valid) begin
          state_d = i_block ^ i_round_key;
          round_d = KW'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = i_dp_result;
        if (round_q == LAST_ROUND) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + KW'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decode registered state only, never the incoming valid/ready.
  always_comb begin
    o_ready    = (fsm_q == IDLE);
    o_valid    = (fsm_q == DONE);
    o_busy     = (fsm_q != IDLE);
    o_key_idx  = (fsm_q == ROUND) ? round_q : '0;
    o_dp_state = state_q;
    o_dp_final = (fsm_q == ROUND) && (round_q == LAST_ROUND);
    o_block    = (fsm_q == DONE) ? state_q : '0;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: NR=10 and NR=14 instances driven against
// a behavioural AES model (datapath, key schedule and whole-block reference).
module tb_aes_round_ctrl;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  logic i_rst;

  logic         valid_a, ready_a, o_valid_a, i_ready_a, final_a, busy_a;
  logic [127:0] block_a, o_block_a, rkey_a, dps_a, dpr_a;
  logic [3:0]   kidx_a;
  logic         valid_b, ready_b, o_valid_b, i_ready_b, final_b, busy_b;
  logic [127:0] block_b, o_block_b, rkey_b, dps_b, dpr_b;
  logic [3:0]   kidx_b;

  aes_round_ctrl #(.NR(10), .KW(4)) u_dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(valid_a), .o_ready(ready_a),
    .i_block(block_a), .o_valid(o_valid_a), .i_ready(i_ready_a), .o_block(o_block_a),
    .o_key_idx(kidx_a), .i_round_key(rkey_a), .o_dp_state(dps_a), .o_dp_final(final_a),
    .i_dp_result(dpr_a), .o_busy(busy_a)
  );

  aes_round_ctrl #(.NR(14), .KW(4)) u_dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(valid_b), .o_ready(ready_b),
    .i_block(block_b), .o_valid(o_valid_b), .i_ready(i_ready_b), .o_block(o_block_b),
    .o_key_idx(kidx_b), .i_round_key(rkey_b), .o_dp_state(dps_b), .o_dp_final(final_b),
    .i_dp_result(dpr_b), .o_busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [0:255];
  int           sbox_ver = 0;
  logic [255:0] key_a, key_b;
  logic [127:0] rk_a [0:15];
  logic [127:0] rk_b [0:15];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from the GF(2^8) inverse plus affine map rather than a typed table.
  task automatic init_sbox();
    logic [7:0] inv, r, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox[byte_at(s, r + 4*((c + r) % 4))];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a [0:3];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = byte_at(s, 4*c + k);
      for (int k = 0; k < 4; k++)
        o[127-8*(4*c+k) -: 8] = xt(a[k]) ^ xt(a[(k+1)%4]) ^ a[(k+1)%4] ^ a[(k+2)%4] ^ a[(k+3)%4];
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; nk is the key length in 32-bit words.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int idx);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [127:0] s;
    s = pt ^ round_key(key, nk, 0);
    for (int r = 1; r <= nk + 6; r++) begin
      s = sub_shift(s);
      if (r < nk + 6) s = mix(s);
      s = s ^ round_key(key, nk, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] dp_round(input logic [127:0] s, input logic fin, input logic [127:0] k);
    logic [127:0] t;
    t = sub_shift(s);
    if (!fin) t = mix(t);
    return t ^ k;
  endfunction

  assign rkey_a = rk_a[kidx_a];
  assign rkey_b = rk_b[kidx_b];
  always_comb dpr_a = (sbox_ver == 0) ? '0 : dp_round(dps_a, final_a, rkey_a);
  always_comb dpr_b = (sbox_ver == 0) ? '0 : dp_round(dps_b, final_b, rkey_b);

  task automatic load_a(input logic [127:0] k);
    key_a = {k, 128'h0};
    for (int i = 0; i < 16; i++) rk_a[i] = (i <= 10) ? round_key(key_a, 4, i) : '0;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] b);
    valid_a = v;
    block_a = b;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block through instance A: latency, key-index walk, final flag, ciphertext, stall, handoff.
  task automatic run_a(input logic [127:0] pt, input int stall, input bit abuse,
                       input bit has_exp, input logic [127:0] exp_ct);
    logic [127:0] ref_ct;
    int lat = -1;
    ref_ct = aes_ref(pt, key_a, 4);
    checkOutput("accept_ready", ready_a, 1);
    applyStimulus(1'b1, pt);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge i_clk); #1;
      if (o_valid_a) begin
        lat = n;
        applyStimulus(1'b0, '0);
      end else begin
        if (abuse) applyStimulus(1'($urandom), rand128());
        else applyStimulus(1'b0, '0);
        checkOutput("key_idx", 128'(kidx_a), 128'(n));
        checkOutput("dp_final", 128'(final_a), 128'(n == 10));
      end
    end
    checkOutput("latency", 128'(lat), 128'd11);
    checkOutput("ct_ref", o_block_a, ref_ct);
    if (has_exp) checkOutput("ct_fips", o_block_a, exp_ct);
    for (int s = 0; s < stall; s++) begin
      @(posedge i_clk); #1;
      checkOutput("stall_block", o_block_a, ref_ct);
      checkOutput("stall_valid", 128'(o_valid_a), 1);
      checkOutput("stall_ready", 128'(ready_a), 0);
    end
    i_ready_a = 1'b1;
    #1;
    checkOutput("handoff_ready_low", 128'(ready_a), 0);
    checkOutput("handoff_valid_high", 128'(o_valid_a), 1);
    @(posedge i_clk); #1;
    i_ready_a = 1'b0;
    checkOutput("post_valid", 128'(o_valid_a), 0);
    checkOutput("post_ready", 128'(ready_a), 1);
    checkOutput("post_busy", 128'(busy_a), 0);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] exp_q [$];
  int accepts, outs, last_acc, lat_b;
  bit acc, seen_v;

  initial begin
    i_rst = 1'b1;
    valid_a = 0; block_a = '0; i_ready_a = 0;
    valid_b = 0; block_b = '0; i_ready_b = 0;
    for (int i = 0; i < 16; i++) begin rk_a[i] = '0; rk_b[i] = '0; end
    init_sbox();
    sbox_ver = 1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_valid", 128'(o_valid_a), 0);
    checkOutput("rst_ready", 128'(ready_a), 1);
    checkOutput("rst_block", o_block_a, '0);
    checkOutput("rst_key_idx", 128'(kidx_a), 0);
    checkOutput("rst_final", 128'(final_a), 0);
    checkOutput("rst_busy", 128'(busy_a), 0);
    checkOutput("rst_dp_state", dps_a, '0);
    checkOutput("rst_ready_b", 128'(ready_b), 1);

    $display("[TB] FIPS-197 C.1");
    load_a(C1_KEY);
    run_a(C1_PT, 0, 1'b0, 1'b1, C1_CT);

    $display("[TB] FIPS-197 B with 20-cycle stall");
    load_a(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_a(128'h3243f6a8885a308d313198a2e0370734, 20, 1'b0, 1'b1,
          128'h3925841d02dc09fbdc118597196a0b32);

    $display("[TB] back-to-back random blocks");
    load_a(rand128());
    i_ready_a = 1'b1;
    applyStimulus(1'b1, rand128());
    exp_q.delete();
    accepts = 0; outs = 0; last_acc = -1;
    for (int k = 0; k < 120 && outs < 4; k++) begin
      checkOutput("ready_in_done", 128'(ready_a & o_valid_a), 0);
      if (o_valid_a) begin
        if (exp_q.size() == 0) checkOutput("b2b_unexpected", 1, 0);
        else checkOutput("b2b_ct", o_block_a, exp_q.pop_front());
        outs++;
      end
      acc = valid_a && ready_a;
      if (acc) begin
        exp_q.push_back(aes_ref(block_a, key_a, 4));
        if (last_acc >= 0) checkOutput("b2b_spacing", 128'(k - last_acc), 128'd12);
        last_acc = k;
        accepts++;
      end
      @(posedge i_clk); #1;
      if (acc) begin
        if (accepts == 4) applyStimulus(1'b0, '0);
        else applyStimulus(1'b1, rand128());
      end
    end
    checkOutput("b2b_outputs", 128'(outs), 4);
    checkOutput("b2b_accepts", 128'(accepts), 4);
    i_ready_a = 1'b0;
    @(posedge i_clk); #1;

    $display("[TB] reset at round 5");
    load_a(C1_KEY);
    applyStimulus(1'b1, C1_PT);
    for (int n = 0; n < 20 && kidx_a != 4'd5; n++) begin
      @(posedge i_clk); #1;
      applyStimulus(1'b0, '0);
    end
    checkOutput("reached_round5", 128'(kidx_a), 5);
    i_rst = 1'b1;
    applyStimulus(1'b1, rand128());
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("mid_rst_ready", 128'(ready_a), 1);
    checkOutput("mid_rst_valid", 128'(o_valid_a), 0);
    checkOutput("mid_rst_busy", 128'(busy_a), 0);
    seen_v = 0;
    repeat (15) begin
      @(posedge i_clk); #1;
      seen_v = seen_v | o_valid_a | busy_a;
    end
    checkOutput("mid_rst_no_output", 128'(seen_v), 0);
    run_a(C1_PT, 0, 1'b0, 1'b1, C1_CT);

    $display("[TB] handshake abuse during rounds");
    load_a(rand128());
    run_a(rand128(), 3, 1'b1, 1'b0, '0);

    $display("[TB] FIPS-197 C.3 on NR=14");
    key_b = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    for (int i = 0; i < 16; i++) rk_b[i] = (i <= 14) ? round_key(key_b, 8, i) : '0;
    checkOutput("b_accept_ready", 128'(ready_b), 1);
    valid_b = 1'b1;
    block_b = C1_PT;
    lat_b = -1;
    for (int n = 1; n <= 40 && lat_b < 0; n++) begin
      @(posedge i_clk); #1;
      valid_b = 1'b0;
      if (o_valid_b) lat_b = n;
      else begin
        checkOutput("b_key_idx", 128'(kidx_b), 128'(n));
        checkOutput("b_dp_final", 128'(final_b), 128'(n == 14));
      end
    end
    checkOutput("b_latency", 128'(lat_b), 128'd15);
    checkOutput("b_ct_fips", o_block_b, 128'h8ea2b7ca516745bfeafc49904b496089);
    checkOutput("b_ct_ref", o_block_b, aes_ref(C1_PT, key_b, 8));
    i_ready_b = 1'b1;
    @(posedge i_clk); #1;
    i_ready_b = 1'b0;
    checkOutput("b_post_ready", 128'(ready_b), 1);
    checkOutput("b_post_valid", 128'(o_valid_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption round controller. It owns the 128-bit state register, the round counter and the in/out valid/ready handshakes. Each cycle it drives the current state into an external combinational round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, with MixColumns bypassed on the final round) and selects the round key from an external key-schedule store. It sits between the block-level stream interface and the round datapath plus key memory.

Parameters:
NR, 10, number of AES rounds. Legal values are 10, 12 and 14; any other value is a synthesis-time error.
KW, 4, round-index width. Must satisfy 2^KW > NR.

Ports:
i_clk  input  1  clock; all logic is on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  plaintext block valid.
o_ready  output  1  controller can accept a block.
i_block  input  128  plaintext; byte 0 in [127:120], column-major.
o_valid  output  1  ciphertext valid.
i_ready  input  1  downstream accepts ciphertext.
o_block  output  128  ciphertext; same byte order as i_block.
o_key_idx  output  KW  round-key index presented to the key store, which reads combinationally in the same cycle.
i_round_key  input  128  round key for o_key_idx.
o_dp_state  output  128  state fed to the round datapath.
o_dp_final  output  1  final round; the datapath bypasses MixColumns.
i_dp_result  input  128  datapath output, including AddRoundKey with i_round_key.
o_busy  output  1  high in ROUND or DONE.

Behaviour:
- Reset: i_rst is sampled only at a rising edge of i_clk and takes priority over all other inputs.
- Values after a reset edge: state=IDLE, state_q=0, round_q=0, o_valid=0, o_ready=1, o_block=0, o_key_idx=0, o_dp_final=0, o_busy=0.
- Reset mid-operation: an in-flight block is discarded with no output, and i_valid is ignored in that cycle.
- FSM states are IDLE, ROUND and DONE.
- IDLE: o_ready=1 and o_key_idx=0.
  - On i_valid&&o_ready: state_q <= i_block ^ i_round_key (initial AddRoundKey), round_q <= 1, go to ROUND.
  - Otherwise hold.
- ROUND:
  - Drives o_ready=0, o_key_idx=round_q, o_dp_state=state_q and o_dp_final=(round_q==NR).
  - Each cycle: state_q <= i_dp_result.
  - If round_q==NR: go to DONE and leave round_q unchanged. Otherwise round_q <= round_q+1.
- DONE:
  - Drives o_valid=1 and o_block=state_q.
  - o_block and o_valid hold stable while i_ready=0, for an unbounded stall.
  - On i_ready: go to IDLE, round_q <= 0, o_valid=0 on the next cycle.
- o_ready is low in DONE even if i_ready=1 in the same cycle. A new block is accepted at the earliest on the cycle after the handoff, so there is no same-cycle turnaround.
- o_dp_state=state_q and o_dp_final=0 outside ROUND. The datapath output is ignored outside ROUND.
- Latency: with acceptance at edge E0, o_valid is first high in the cycle after edge E0+NR. That is NR+1 cycles from the accept cycle.
- Minimum block period is NR+2 cycles (accept, NR rounds, DONE handshake). Back-to-back with i_ready tied high gives 12 cycles for NR=10.
- round_q never exceeds NR, so there is no wrap-around.
- i_block and i_valid changing while o_ready=0 has no effect.
- o_valid, o_ready and o_busy are decoded from registered FSM state only. They have no combinational path from i_valid or i_ready.

Test Plan:
- FIPS-197 C.1: NR=10, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, with a reference datapath and key-store model. Required: o_block=69c4e0d86a7b0430d8cdb78070b4c55a, o_valid first high 11 cycles after the accept cycle, o_key_idx sequence 0,1..10, o_dp_final high only at round 10.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, i_ready held 0 for 20 cycles after o_valid. Required: o_block=3925841d02dc09fbdc118597196a0b32 stable throughout the stall, o_ready=0 until the cycle after i_ready.
- Back-to-back: i_valid and i_ready tied 1, 4 blocks. Required: accepts spaced exactly 12 cycles apart, all ciphertexts correct, o_ready never high in DONE.
- Reset mid-round: assert i_rst at round 5 for 1 cycle. Required: next cycle o_ready=1, o_valid=0, o_busy=0, no ciphertext emitted; the following C.1 block still encrypts correctly.
- NR=14 build with the FIPS-197 C.3 vector (key 00..1f). Required: ciphertext 8ea2b7ca516745bfeafc49904b496089, o_valid 15 cycles after the accept cycle.
- Handshake abuse: toggle i_valid and i_block every cycle during ROUND. Required: no state change, and the result matches the originally accepted block.
